hack_ram_read_port: RTL and testbench

//   Read side of the Hack data memory. Owns a synchronous block-RAM array

---
 rtl/hack_mem_pkg.sv | 16 +
 rtl/ram_sync_1r1w.sv | 29 ++
 rtl/hack_ram_read_port.sv | 125 ++++++++++++
 tb/tb_hack_ram_read_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared widths, word/address types and queue sizing helper for the Hack data memory.
// Optional macro READ_BYPASS_EN (see hack_ram_read_port) selects write-first reads.
package hack_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 14;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    // Pointer width for a circular queue of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_sync_1r1w.sv
// Synchronous block-RAM: one write port, one registered read port, no reset.
// A read and write to the same address at one edge returns the old word.
module ram_sync_1r1w #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hack_ram_read_port.sv
// Hack data memory with a valid/ready read port and a credit-managed response queue.
// Define READ_BYPASS_EN for write-first same-address reads; default is read-first.
module hack_ram_read_port
    import hack_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OUT_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int unsigned PW = ptr_width(OUT_DEPTH);
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    logic [PW-1:0]         head_q, head_n, tail_q, tail_n;
    logic [CW-1:0]         count_q, count_n;
    logic [CW:0]           credit;
    logic                  inflight_q;
    logic                  req_ready_q, req_ready_n;
    logic                  rsp_valid_q, rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_n;
    logic [DATA_WIDTH-1:0] queue_mem [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  accept, push, pop;

    assign accept = req_valid & req_ready_q;
    assign push   = inflight_q;
    assign pop    = rsp_valid_q & rsp_ready;

    ram_sync_1r1w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (req_addr),
        .rd_data (ram_rd_data)
    );

`ifdef READ_BYPASS_EN
    // Remember a same-edge write hit so the pushed word is the freshly written one.
    logic                  byp_hit_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(posedge clock) begin
        if (!not_reset) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else if (accept) begin
            byp_hit_q  <= wr_en && (wr_addr == req_addr);
            byp_data_q <= wr_data;
        end
    end

    assign push_word = byp_hit_q ? byp_data_q : ram_rd_data;
`else
    assign push_word = ram_rd_data;
`endif

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next queue state; ready/valid/data are precomputed so every output is a flop.
    always_comb begin
        head_n      = pop  ? next_ptr(head_q) : head_q;
        tail_n      = push ? next_ptr(tail_q) : tail_q;
        count_n     = count_q + CW'(push) - CW'(pop);
        credit      = (CW+1)'(count_n) + (CW+1)'(accept);
        req_ready_n = credit < (CW+1)'(OUT_DEPTH);
        rsp_valid_n = (count_n != '0);
        rsp_data_n  = queue_mem[head_n];
        // The pushed word becomes the head when nothing older remains queued.
        if (push && (count_q == CW'(pop))) begin
            rsp_data_n = push_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!not_reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            head_q      <= head_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            inflight_q  <= accept;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
        end
    end

    // Queue storage needs no reset; stale entries sit behind the cleared pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            queue_mem[tail_q] <= push_word;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_hack_ram_read_port.sv
// Directed self-checking bench for hack_ram_read_port (default OUT_DEPTH=4).
module tb_hack_ram_read_port;
    import hack_mem_pkg::*;

    logic  clock = 1'b0;
    logic  not_reset;
    logic  wr_en;
    addr_t wr_addr;
    word_t wr_data;
    logic  req_valid;
    logic  req_ready;
    addr_t req_addr;
    logic  rsp_valid;
    logic  rsp_ready;
    word_t rsp_data;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    word_t got_q[$];
    int    got_cyc[$];
    word_t exp_same;

    hack_ram_read_port dut (
        .clock     (clock),
        .not_reset (not_reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Inputs are stable by the falling edge, so fires seen here happen at the next rising edge.
    always @(negedge clock) begin
        if (not_reset && rsp_valid && rsp_ready) begin
            got_q.push_back(rsp_data);
            got_cyc.push_back(cyc);
        end
        if (not_reset && req_valid && req_ready) acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ram_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = addr_t'(a);
        wr_data = word_t'(d);
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        not_reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

        // Reset held two cycles, then released
        step(); step();
        not_reset = 1'b1;
        step();
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);

        // Write then read address 5: two-cycle latency
        ram_write(5, 16'h1234);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = addr_t'(5);
        step();
        req_valid = 1'b0;
        check_eq("lat_valid_c1", 32'(rsp_valid), 32'd0);
        step();
        check_eq("lat_valid_c2", 32'(rsp_valid), 32'd1);
        check_eq("lat_data",     32'(rsp_data),  32'h1234);
        step();
        got_q.delete(); got_cyc.delete();

        // Streaming reads of 0..7 preloaded with addr*3
        for (int i = 0; i < 8; i++) ram_write(i, i * 3);
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = addr_t'(i);
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        check_eq("stream_count", 32'(got_q.size()), 32'd8);
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("stream_data%0d", i), 32'(got_q[i]), 32'(i * 3));
            for (int i = 1; i < 8; i++)
                check_eq($sformatf("stream_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
        end

        // Backpressure: six offered, four accepted, then drain
        got_q.delete(); got_cyc.delete();
        acc_cnt = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_addr = addr_t'(i);
            step();
        end
        req_valid = 1'b0;
        check_eq("bp_accepted",  32'(acc_cnt),   32'd4);
        check_eq("bp_req_ready", 32'(req_ready), 32'd0);
        check_eq("bp_head",      32'(rsp_data),  32'd0);
        rsp_ready = 1'b1;
        repeat (6) step();
        check_eq("bp_drain_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("bp_drain%0d", i), 32'(got_q[i]), 32'(i * 3));
        end
        check_eq("bp_ready_back", 32'(req_ready), 32'd1);

        // Same-edge write and read of address 9
        got_q.delete(); got_cyc.delete();
        ram_write(9, 16'h0001);
`ifdef READ_BYPASS_EN
        exp_same = 16'hBEEF;
`else
        exp_same = 16'h0001;
`endif
        wr_en = 1'b1; wr_addr = addr_t'(9); wr_data = 16'hBEEF;
        req_valid = 1'b1; req_addr = addr_t'(9);
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        repeat (3) step();
        req_valid = 1'b1; req_addr = addr_t'(9);
        step();
        req_valid = 1'b0;
        repeat (3) step();
        check_eq("same_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check_eq("same_edge_rsp", 32'(got_q[0]), 32'(exp_same));
            check_eq("later_rsp",     32'(got_q[1]), 32'hBEEF);
        end

        // Reset with three queued words and one in flight
        got_q.delete(); got_cyc.delete();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_addr = addr_t'(i);
            step();
        end
        req_valid = 1'b0;
        check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check_eq("pre_rst_ready", 32'(req_ready), 32'd0);
        not_reset = 1'b0;
        step();
        not_reset = 1'b1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_data",  32'(rsp_data),  32'd0);
        rsp_ready = 1'b1;
        repeat (8) step();
        check_eq("mid_rst_no_rsp",   32'(got_q.size()), 32'd0);
        check_eq("mid_rst_valid_lt", 32'(rsp_valid),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
